// File: rtl/lsu_axim_bridge_pkg.sv
// Shared definitions for the LSU-to-AXI4-Lite master bridge:
// AXI response codes, bridge state encoding and a response helper.
package lsu_axim_bridge_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WADDR = 3'd1,
        S_WRESP = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4,
        S_DONE  = 3'd5
    } bridge_state_e;

    // Only OKAY counts as success; EXOKAY is meaningless on AXI4-Lite.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/lsu_axim_bridge.sv
// LSU request port to AXI4-Lite master bridge, one outstanding transaction.
// Ports: LSU handshake (hs_ls4axim_val / hs_axim4ls_rdy), request payload
// (i_axim_wen, i_axim_ren, i_adr, i_wdat), response (o_rdat, o_axim_err),
// and the five AXI4-Lite channels AW, W, B, AR, R. All outputs registered.
module lsu_axim_bridge
    import lsu_axim_bridge_pkg::*;
#(
    parameter logic [2:0] AXI_PROT = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_ls4axim_val,
    output logic        hs_axim4ls_rdy,
    input  logic [3:0]  i_axim_wen,
    input  logic        i_axim_ren,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_wdat,
    output logic [31:0] o_rdat,
    output logic        o_axim_err,
    output logic        o_awvalid,
    input  logic        i_awready,
    output logic [31:0] o_awaddr,
    output logic [2:0]  o_awprot,
    output logic        o_wvalid,
    input  logic        i_wready,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    input  logic        i_bvalid,
    output logic        o_bready,
    input  logic [1:0]  i_bresp,
    output logic        o_arvalid,
    input  logic        i_arready,
    output logic [31:0] o_araddr,
    output logic [2:0]  o_arprot,
    input  logic        i_rvalid,
    output logic        o_rready,
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_rresp
);

    bridge_state_e state_q, state_d;

    logic [31:0] adr_q,  adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [3:0]  wen_q,  wen_d;

    logic        awvalid_q, awvalid_d;
    logic        wvalid_q,  wvalid_d;
    logic        bready_q,  bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q,  rready_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q,  w_done_d;

    logic        rdy_q,  rdy_d;
    logic [31:0] rdat_q, rdat_d;
    logic        err_q,  err_d;

    // Handshakes for this cycle; valids are registered, so these
    // only look at our own flop outputs plus the slave's readies.
    logic aw_hs;
    logic w_hs;
    logic aw_fin;
    logic w_fin;

    assign aw_hs  = awvalid_q & i_awready;
    assign w_hs   = wvalid_q  & i_wready;
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q  | w_hs;

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        wen_d     = wen_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdy_d     = 1'b0;
        rdat_d    = rdat_q;
        err_d     = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (hs_ls4axim_val) begin
                    adr_d  = i_adr;
                    wdat_d = i_wdat;
                    wen_d  = i_axim_wen;
                    if (i_axim_wen != 4'b0000) begin
                        state_d   = S_WADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else if (i_axim_ren) begin
                        state_d   = S_RADDR;
                        arvalid_d = 1'b1;
                    end else begin
                        // Empty request: acknowledge without bus traffic.
                        state_d = S_DONE;
                        rdy_d   = 1'b1;
                        rdat_d  = 32'h0;
                        err_d   = 1'b0;
                    end
                end
            end
            S_WADDR: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_fin && w_fin) begin
                    state_d  = S_WRESP;
                    bready_d = 1'b1;
                end
            end
            S_WRESP: begin
                if (i_bvalid) begin
                    state_d  = S_DONE;
                    bready_d = 1'b0;
                    rdy_d    = 1'b1;
                    rdat_d   = 32'h0;
                    err_d    = resp_is_err(i_bresp);
                end
            end
            S_RADDR: begin
                if (i_arready) begin
                    state_d   = S_RDATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            S_RDATA: begin
                if (i_rvalid) begin
                    state_d  = S_DONE;
                    rready_d = 1'b0;
                    rdy_d    = 1'b1;
                    rdat_d   = i_rdata;
                    err_d    = resp_is_err(i_rresp);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            adr_q     <= 32'h0;
            wdat_q    <= 32'h0;
            wen_q     <= 4'h0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdy_q     <= 1'b0;
            rdat_q    <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            wen_q     <= wen_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdy_q     <= rdy_d;
            rdat_q    <= rdat_d;
            err_q     <= err_d;
        end
    end

    assign hs_axim4ls_rdy = rdy_q;
    assign o_rdat         = rdat_q;
    assign o_axim_err     = err_q;

    assign o_awvalid = awvalid_q;
    assign o_awaddr  = adr_q;
    assign o_awprot  = AXI_PROT;
    assign o_wvalid  = wvalid_q;
    assign o_wdata   = wdat_q;
    assign o_wstrb   = wen_q;
    assign o_bready  = bready_q;
    assign o_arvalid = arvalid_q;
    assign o_araddr  = adr_q;
    assign o_arprot  = AXI_PROT;
    assign o_rready  = rready_q;

endmodule

// File: tb/tb_lsu_axim_bridge.sv
// Self-checking bench for lsu_axim_bridge: programmable-latency AXI slave,
// transaction-level expectation model and a per-cycle protocol monitor.
module tb_lsu_axim_bridge;

    localparam int K_NOP   = 0;
    localparam int K_WRITE = 1;
    localparam int K_READ  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs_ls4axim_val = 1'b0;
    logic        hs_axim4ls_rdy;
    logic [3:0]  i_axim_wen = 4'h0;
    logic        i_axim_ren = 1'b0;
    logic [31:0] i_adr = 32'h0;
    logic [31:0] i_wdat = 32'h0;
    logic [31:0] o_rdat;
    logic        o_axim_err;
    logic        o_awvalid;
    logic        i_awready = 1'b0;
    logic [31:0] o_awaddr;
    logic [2:0]  o_awprot;
    logic        o_wvalid;
    logic        i_wready = 1'b0;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        i_bvalid = 1'b0;
    logic        o_bready;
    logic [1:0]  i_bresp = 2'b00;
    logic        o_arvalid;
    logic        i_arready = 1'b0;
    logic [31:0] o_araddr;
    logic [2:0]  o_arprot;
    logic        i_rvalid = 1'b0;
    logic        o_rready;
    logic [31:0] i_rdata = 32'h0;
    logic [1:0]  i_rresp = 2'b00;

    lsu_axim_bridge dut (
        .clk(clk), .rst(rst),
        .hs_ls4axim_val(hs_ls4axim_val), .hs_axim4ls_rdy(hs_axim4ls_rdy),
        .i_axim_wen(i_axim_wen), .i_axim_ren(i_axim_ren),
        .i_adr(i_adr), .i_wdat(i_wdat),
        .o_rdat(o_rdat), .o_axim_err(o_axim_err),
        .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_awaddr(o_awaddr), .o_awprot(o_awprot),
        .o_wvalid(o_wvalid), .i_wready(i_wready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
        .o_arvalid(o_arvalid), .i_arready(i_arready),
        .o_araddr(o_araddr), .o_arprot(o_arprot),
        .i_rvalid(i_rvalid), .o_rready(o_rready),
        .i_rdata(i_rdata), .i_rresp(i_rresp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // slave configuration
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [1:0]  cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;

    // current transaction model
    int          cur_kind = K_NOP;
    logic [31:0] cur_adr = 32'h0;
    logic [31:0] cur_wdat = 32'h0;
    logic [3:0]  cur_wen = 4'h0;
    logic [31:0] exp_rdat = 32'h0;
    logic        exp_err = 1'b0;

    int rdy_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // AXI slave: readies after a programmed number of valid cycles,
    // responses after a programmed number of ready cycles.
    initial begin
        int aw_c, w_c, ar_c, b_c, r_c;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
                i_awready = 0; i_wready = 0; i_arready = 0;
                i_bvalid = 0; i_rvalid = 0; i_rdata = 0;
            end else begin
                i_awready = o_awvalid && (aw_c >= aw_dly);
                aw_c = o_awvalid ? aw_c + 1 : 0;
                i_wready = o_wvalid && (w_c >= w_dly);
                w_c = o_wvalid ? w_c + 1 : 0;
                i_arready = o_arvalid && (ar_c >= ar_dly);
                ar_c = o_arvalid ? ar_c + 1 : 0;
                i_bvalid = o_bready && (b_c >= b_dly);
                b_c = o_bready ? b_c + 1 : 0;
                i_bresp = cfg_bresp;
                i_rvalid = o_rready && (r_c >= r_dly);
                r_c = o_rready ? r_c + 1 : 0;
                i_rdata = i_rvalid ? cfg_rdata : 32'h0;
                i_rresp = cfg_rresp;
            end
        end
    end

    // Per-cycle monitor against the transaction model.
    initial begin
        logic aw_pend, w_pend, ar_pend, aw_acc, w_acc, prev_rdy;
        logic [31:0] last_rdat;
        logic last_err;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        aw_acc = 0; w_acc = 0; prev_rdy = 0;
        last_rdat = 0; last_err = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_pend = 0; w_pend = 0; ar_pend = 0;
                aw_acc = 0; w_acc = 0; prev_rdy = 0;
                last_rdat = 0; last_err = 0;
            end else begin
                if (hs_ls4axim_val) begin
                    aw_acc = 0;
                    w_acc = 0;
                end
                if (aw_pend) chk("awvalid_hold", 32'(o_awvalid), 32'd1);
                if (w_pend)  chk("wvalid_hold", 32'(o_wvalid), 32'd1);
                if (ar_pend) chk("arvalid_hold", 32'(o_arvalid), 32'd1);
                if (o_awvalid) begin
                    chk("awaddr", o_awaddr, cur_adr);
                    chk("awprot", 32'(o_awprot), 32'd0);
                end
                if (o_wvalid) begin
                    chk("wdata", o_wdata, cur_wdat);
                    chk("wstrb", 32'(o_wstrb), 32'(cur_wen));
                end
                if (o_arvalid) begin
                    chk("araddr", o_araddr, cur_adr);
                    chk("arprot", 32'(o_arprot), 32'd0);
                end
                if (o_bready)
                    chk("bready_after_aw_w", 32'(aw_acc && w_acc), 32'd1);
                if (cur_kind != K_WRITE)
                    chk("no_write_chan", 32'(o_awvalid | o_wvalid | o_bready), 32'd0);
                if (cur_kind != K_READ)
                    chk("no_read_chan", 32'(o_arvalid | o_rready), 32'd0);
                if (hs_axim4ls_rdy) begin
                    chk("rdy_one_cycle", 32'(prev_rdy), 32'd0);
                    chk("rdat", o_rdat, exp_rdat);
                    chk("err", 32'(o_axim_err), 32'(exp_err));
                    rdy_cnt++;
                    last_rdat = o_rdat;
                    last_err = o_axim_err;
                end else begin
                    chk("rdat_held", o_rdat, last_rdat);
                    chk("err_held", 32'(o_axim_err), 32'(last_err));
                end
                aw_pend = o_awvalid && !i_awready;
                w_pend  = o_wvalid && !i_wready;
                ar_pend = o_arvalid && !i_arready;
                if (o_awvalid && i_awready) aw_acc = 1;
                if (o_wvalid && i_wready) w_acc = 1;
                prev_rdy = hs_axim4ls_rdy;
            end
        end
    end

    task automatic set_model(input logic [3:0] wen, input logic ren,
                             input logic [31:0] adr, input logic [31:0] wdat);
        cur_adr = adr;
        cur_wdat = wdat;
        cur_wen = wen;
        if (wen != 4'h0) begin
            cur_kind = K_WRITE;
            exp_rdat = 32'h0;
            exp_err = (cfg_bresp != 2'b00);
        end else if (ren) begin
            cur_kind = K_READ;
            exp_rdat = cfg_rdata;
            exp_err = (cfg_rresp != 2'b00);
        end else begin
            cur_kind = K_NOP;
            exp_rdat = 32'h0;
            exp_err = 1'b0;
        end
    endtask

    // One request: val for one cycle, then garbage on the payload
    // inputs; returns cycles from the val cycle to the rdy cycle.
    task automatic issue(input logic [3:0] wen, input logic ren,
                         input logic [31:0] adr, input logic [31:0] wdat,
                         output int lat);
        int n;
        int cnt0;
        bit seen;
        @(posedge clk);
        #1;
        set_model(wen, ren, adr, wdat);
        cnt0 = rdy_cnt;
        i_axim_wen = wen;
        i_axim_ren = ren;
        i_adr = adr;
        i_wdat = wdat;
        hs_ls4axim_val = 1'b1;
        @(posedge clk);
        #1;
        hs_ls4axim_val = 1'b0;
        i_axim_wen = 4'hF;
        i_axim_ren = 1'b1;
        i_adr = 32'hA5A5_A5A5;
        i_wdat = 32'h5A5A_5A5A;
        n = 0;
        seen = 0;
        lat = -1;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (hs_axim4ls_rdy) begin
                seen = 1;
                lat = n;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL rdy_timeout: got none within %0d cycles", n);
        end
        @(negedge clk);
        chk("rdy_count", 32'(rdy_cnt - cnt0), 32'd1);
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(hs_axim4ls_rdy), 32'd0);
        chk("rst_valids", 32'({o_awvalid, o_wvalid, o_bready,
                               o_arvalid, o_rready}), 32'd0);
        chk("rst_rdat", o_rdat, 32'h0);
        chk("rst_err", 32'(o_axim_err), 32'd0);
        rst = 1'b0;

        cfg_rdata = 32'hDEAD_BEEF;
        issue(4'h0, 1'b1, 32'h4000_0010, 32'h0, lat);
        chk("zw_read_lat", 32'(lat), 32'd3);
        chk("zw_read_rdat", o_rdat, 32'hDEAD_BEEF);
        chk("zw_read_err", 32'(o_axim_err), 32'd0);

        issue(4'hF, 1'b0, 32'h4000_0020, 32'hCAFE_F00D, lat);
        chk("zw_write_lat", 32'(lat), 32'd3);
        chk("zw_write_rdat", o_rdat, 32'h0);

        w_dly = 2;
        issue(4'b0011, 1'b1, 32'h4000_0030, 32'h1234_5678, lat);
        chk("w_late_lat", 32'(lat), 32'd5);
        chk("w_late_err", 32'(o_axim_err), 32'd0);
        w_dly = 0;

        aw_dly = 3;
        issue(4'b1000, 1'b0, 32'h4000_0034, 32'h0BAD_F00D, lat);
        chk("aw_late_lat", 32'(lat), 32'd6);
        aw_dly = 0;

        ar_dly = 5;
        r_dly = 3;
        cfg_rdata = 32'h0000_1111;
        issue(4'h0, 1'b1, 32'h4000_0040, 32'h0, lat);
        chk("stall_read_lat", 32'(lat), 32'd11);
        chk("stall_read_rdat", o_rdat, 32'h0000_1111);
        ar_dly = 0;
        r_dly = 0;

        cfg_bresp = 2'b10;
        issue(4'b0100, 1'b0, 32'h4000_0050, 32'h7777_7777, lat);
        chk("slverr_err", 32'(o_axim_err), 32'd1);
        chk("slverr_rdat", o_rdat, 32'h0);
        cfg_bresp = 2'b00;

        cfg_rdata = 32'h89AB_CDEF;
        issue(4'h0, 1'b1, 32'h4000_0060, 32'h0, lat);
        chk("okay_clears_err", 32'(o_axim_err), 32'd0);
        chk("okay_rdat", o_rdat, 32'h89AB_CDEF);

        issue(4'h0, 1'b0, 32'h4000_0070, 32'h1111_2222, lat);
        chk("nop_lat", 32'(lat), 32'd1);
        chk("nop_rdat", o_rdat, 32'h0);

        cfg_rresp = 2'b11;
        cfg_rdata = 32'h0F0F_0F0F;
        issue(4'h0, 1'b1, 32'h4000_0080, 32'h0, lat);
        chk("decerr_err", 32'(o_axim_err), 32'd1);
        cfg_rresp = 2'b00;

        // Reset while waiting for read data.
        r_dly = 10;
        @(posedge clk);
        #1;
        set_model(4'h0, 1'b1, 32'h4000_0090, 32'h0);
        i_axim_wen = 4'h0;
        i_axim_ren = 1'b1;
        i_adr = 32'h4000_0090;
        hs_ls4axim_val = 1'b1;
        @(posedge clk);
        #1;
        hs_ls4axim_val = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_rready", 32'(o_rready), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valids", 32'({o_awvalid, o_wvalid, o_bready,
                                     o_arvalid, o_rready}), 32'd0);
        chk("async_rst_rdy", 32'(hs_axim4ls_rdy), 32'd0);
        chk("async_rst_rdat", o_rdat, 32'h0);
        chk("async_rst_err", 32'(o_axim_err), 32'd0);
        r_dly = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        cfg_rdata = 32'h3141_5926;
        issue(4'h0, 1'b1, 32'h4000_00A0, 32'h0, lat);
        chk("post_rst_lat", 32'(lat), 32'd3);
        chk("post_rst_rdat", o_rdat, 32'h3141_5926);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
